// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: one state per datapath step.
// Outputs are registered copies of the incoming state's decode, so they change only with the state.
module multicycle_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   output logic       pc_write,
   output logic       ir_write,
   output logic       mem_wr,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       epc_write,
   output logic [4:0] state_out
);

   typedef enum logic [4:0] {
      ST_RESET    = 5'd0,
      ST_FETCH    = 5'd1,
      ST_DECODE   = 5'd2,
      ST_MEMADDR  = 5'd3,
      ST_MEMREAD  = 5'd4,
      ST_MEMWAIT  = 5'd5,
      ST_MEMWB    = 5'd6,
      ST_MEMWRITE = 5'd7,
      ST_EXEC_R   = 5'd8,
      ST_RWB      = 5'd9,
      ST_BRANCH   = 5'd10,
      ST_JUMP     = 5'd11,
      ST_ADDI_EX  = 5'd12,
      ST_ADDI_WB  = 5'd13,
      ST_EXCEPT   = 5'd14
   } state_t;

   typedef struct packed {
      logic       pcWrite;
      logic       irWrite;
      logic       memWr;
      logic       regWrite;
      logic       regDst;
      logic       memToReg;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic [1:0] pcSource;
      logic       epcWrite;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   state_t r_state;
   state_t w_nextState;
   ctrl_t  r_ctrl;
   logic   r_isBne;
   logic   w_branchTaken;

   // Control word for each state; anything not set here stays 0.
   function automatic ctrl_t decodeState(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         ST_FETCH: begin
            c.irWrite  = 1'b1;
            c.aluSrcB  = 2'd1;
            c.pcWrite  = 1'b1;
         end
         ST_DECODE: begin
            c.aluSrcB  = 2'd3;
         end
         ST_MEMADDR, ST_ADDI_EX: begin
            c.aluSrcA  = 1'b1;
            c.aluSrcB  = 2'd2;
         end
         ST_MEMWB: begin
            c.regWrite = 1'b1;
            c.memToReg = 1'b1;
         end
         ST_MEMWRITE: begin
            c.memWr    = 1'b1;
         end
         ST_EXEC_R: begin
            c.aluSrcA  = 1'b1;
            c.aluOp    = 2'd2;
         end
         ST_RWB: begin
            c.regWrite = 1'b1;
            c.regDst   = 1'b1;
         end
         ST_BRANCH: begin
            c.aluSrcA  = 1'b1;
            c.aluOp    = 2'd1;
            c.pcSource = 2'd1;
         end
         ST_JUMP: begin
            c.pcSource = 2'd2;
            c.pcWrite  = 1'b1;
         end
         ST_ADDI_WB: begin
            c.regWrite = 1'b1;
         end
         ST_EXCEPT: begin
            c.epcWrite = 1'b1;
            c.pcSource = 2'd3;
            c.pcWrite  = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Next-state logic; opcode is only looked at in DECODE and MEMADDR.
   always_comb begin
      w_nextState = ST_RESET;
      case (r_state)
         ST_RESET:    w_nextState = ST_FETCH;
         ST_FETCH:    w_nextState = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OP_RTYPE:       w_nextState = ST_EXEC_R;
               OP_LW, OP_SW:   w_nextState = ST_MEMADDR;
               OP_BEQ, OP_BNE: w_nextState = ST_BRANCH;
               OP_J:           w_nextState = ST_JUMP;
               OP_ADDI:        w_nextState = ST_ADDI_EX;
               default:        w_nextState = ST_EXCEPT;
            endcase
         end
         ST_MEMADDR:  w_nextState = (opcode == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
         ST_MEMREAD:  w_nextState = ST_MEMWAIT;
         ST_MEMWAIT:  w_nextState = ST_MEMWB;
         ST_MEMWB:    w_nextState = ST_FETCH;
         ST_MEMWRITE: w_nextState = ST_FETCH;
         ST_EXEC_R:   w_nextState = ST_RWB;
         ST_RWB:      w_nextState = ST_FETCH;
         ST_BRANCH:   w_nextState = ST_FETCH;
         ST_JUMP:     w_nextState = ST_FETCH;
         ST_ADDI_EX:  w_nextState = ST_ADDI_WB;
         ST_ADDI_WB:  w_nextState = ST_FETCH;
         ST_EXCEPT:   w_nextState = ST_FETCH;
         default:     w_nextState = ST_RESET;
      endcase
   end

   // State, registered control word, and the beq/bne flavour captured at decode
   // so BRANCH does not need to look at opcode again.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_RESET;
         r_ctrl  <= '0;
         r_isBne <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_ctrl  <= decodeState(w_nextState);
         if (r_state == ST_DECODE) begin
            r_isBne <= (opcode == OP_BNE);
         end
      end
   end

   assign w_branchTaken = (r_state == ST_BRANCH) && (r_isBne ? ~zero : zero);

   assign pc_write   = r_ctrl.pcWrite | w_branchTaken;
   assign ir_write   = r_ctrl.irWrite;
   assign mem_wr     = r_ctrl.memWr;
   assign reg_write  = r_ctrl.regWrite;
   assign reg_dst    = r_ctrl.regDst;
   assign mem_to_reg = r_ctrl.memToReg;
   assign alu_src_a  = r_ctrl.aluSrcA;
   assign alu_src_b  = r_ctrl.aluSrcB;
   assign alu_op     = r_ctrl.aluOp;
   assign pc_source  = r_ctrl.pcSource;
   assign epc_write  = r_ctrl.epcWrite;
   assign state_out  = r_state;

endmodule
